// File: rtl/seq_detect_pkg.sv
// Shared defaults and state encoding for the serial pattern detector.
package seq_detect_pkg;

  localparam int         PAT_W_DEF   = 4;
  localparam int         CNT_W_DEF   = 8;
  localparam logic [3:0] PAT_RST_DEF = 4'b1011;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    ARMED
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment lands on 1 so that event is not lost.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CNT_W'(inc);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_n.sv
// Serial pattern detector: shift history, fill tracking, comparator and a
// registered one-cycle match pulse, with a loadable pattern.
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEF,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             outp,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int                FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat, pat_nxt;
  logic [PAT_W-1:0]  hist, hist_nxt, hist_sh;
  logic [FILL_W-1:0] fill, fill_nxt, fill_inc;
  logic              match;
  state_t            state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat   <= PAT_RST;
      hist  <= '0;
      fill  <= '0;
      outp  <= 1'b0;
      armed <= 1'b0;
    end else begin
      pat   <= pat_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      outp  <= match;
      armed <= (state_nxt == ARMED);
    end
  end

  // A load wins over a valid bit in the same cycle; that bit is dropped.
  always_comb begin
    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    match    = 1'b0;
    hist_sh  = {hist[PAT_W-2:0], inp};
    fill_inc = (fill == FULL) ? fill : fill + 1'b1;
    if (pat_load) begin
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (in_valid) begin
      hist_nxt = hist_sh;
      match    = (fill_inc == FULL) && (hist_sh == pat);
      fill_nxt = (match && !overlap) ? '0 : fill_inc;
    end
  end

  always_comb begin
    state_nxt = EMPTY;
    if (fill_nxt == FULL) begin
      state_nxt = ARMED;
    end else if (fill_nxt != '0) begin
      state_nxt = FILL;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (match),
    .cnt (match_cnt)
  );

endmodule

// File: doc/seq_detect_n.md
SEQ_DETECT_N -- requirements
Module: seq_detect_n

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_RST, default 4'b1011 (PAT_W bits): pattern value loaded at reset.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 inp  in  1  serial data bit.
REQ-007 in_valid  in  1  inp is sampled only when high.
REQ-008 overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 pat_load  in  1  load pat_in as the new pattern.
REQ-010 pat_in  in  PAT_W  new pattern value, MSB = first bit received.
REQ-011 cnt_clr  in  1  synchronous clear of match_cnt.
REQ-012 outp  out  1  registered one-cycle match pulse.
REQ-013 match_cnt  out  CNT_W  saturating count of matches.
REQ-014 armed  out  1  high when fill count equals PAT_W.

Function
REQ-015 Internal state SHALL be pattern register pat, history shift register hist (PAT_W bits), and fill counter fill (0..PAT_W).
REQ-016 States SHALL be EMPTY (fill=0), FILL (0<fill<PAT_W), and ARMED (fill=PAT_W).
REQ-017 A sampled bit SHALL update hist to {hist[PAT_W-2:0], inp} and increment fill, saturating at PAT_W.
REQ-018 A match SHALL occur on a sampled bit when the post-update fill equals PAT_W and the post-update hist equals pat.
REQ-019 outp SHALL be high exactly in the cycle after the sampling edge of a match, giving 1-cycle latency, and SHALL be low otherwise.
REQ-020 With overlap=1, fill SHALL remain PAT_W after a match, so suffix bits count toward the next match.
REQ-021 With overlap=0, a match SHALL set fill to 0 (EMPTY), so the next match needs PAT_W fresh bits.
REQ-022 With in_valid=0, hist and fill SHALL hold and outp SHALL be 0 in the next cycle.
REQ-023 pat_load=1 SHALL set pat to pat_in, clear hist and fill, and force outp to 0 in the next cycle.
REQ-024 pat_load SHALL take priority over in_valid in the same cycle, and that cycle's inp SHALL be discarded.
REQ-025 The overlap input SHALL be sampled in the same cycle as the matching bit.
REQ-026 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-027 With cnt_clr and a match in the same cycle, match_cnt SHALL become 1; with cnt_clr alone, it SHALL become 0.
REQ-028 armed SHALL be the registered decode fill==PAT_W.

Reset
REQ-029 rst SHALL asynchronously set pat=PAT_RST, hist=0, fill=0, outp=0, match_cnt=0, and armed=0.
REQ-030 Reset asserted mid-stream SHALL discard partial history, and no match SHALL be reported until PAT_W bits are sampled after release.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the PAT_W/CNT_W defaults, the default pattern constant 4'b1011, and the state enum (EMPTY, FILL, ARMED).
REQ-032 The saturating counter with clear SHALL be a sub-module, sat_counter, parametrised by CNT_W.
REQ-033 The top level SHALL contain the shift register, fill counter, comparator and output register only.

Verification
REQ-034 Defaults, overlap=1, in_valid=1, stream 1,0,1,1,0,1,1 -> outp pulses after bits 4 and 7, match_cnt=2.
REQ-035 Same stream with overlap=0 -> single pulse after bit 4, match_cnt=1; stream 1011 then 1011 -> pulses after bits 4 and 8.
REQ-036 Stream 1,0,(in_valid=0 for 3 cycles, inp toggling),1,1 -> one pulse after the 4th valid bit, none during the gap.
REQ-037 pat_load with pat_in=4'b0110, then stream 0,1,1,0 -> pulse after bit 4; stream 1011 -> no pulse.
REQ-038 CNT_W=2, five overlapping matches -> match_cnt sticks at 3; cnt_clr coincident with a match -> match_cnt=1.
REQ-039 rst pulsed after bits 1,0,1, then 1 -> no pulse; outp and match_cnt read 0 immediately on rst assertion.
